// File: rtl/alu_input_pkg.sv
// Shared types and helpers for the ALU input front end.
// - op_t       : latched ALU operation selected by the push buttons.
// - db_state_t : per-button debounce FSM state.
// - op_to_onehot returns the button-style one-hot select as {C, U, D, L, R}.
package alu_input_pkg;

  typedef enum logic [2:0] {
    OP_LEADING_ONES,  // BTNU
    OP_NUM_ONES,      // BTND
    OP_ADD,           // BTNL
    OP_SUB,           // BTNR
    OP_MULT           // BTNC
  } op_t;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } db_state_t;

  localparam op_t OP_RESET = OP_LEADING_ONES;

  // Bit order {C, U, D, L, R}; unused encodings fall back to the reset op so
  // the outputs stay one-hot even if the register were ever corrupted.
  function automatic logic [4:0] op_to_onehot(input op_t op);
    logic [4:0] oh;
    oh = 5'b01000;
    case (op)
      OP_LEADING_ONES: oh = 5'b01000;
      OP_NUM_ONES:     oh = 5'b00100;
      OP_ADD:          oh = 5'b00010;
      OP_SUB:          oh = 5'b00001;
      OP_MULT:         oh = 5'b10000;
      default:         oh = 5'b01000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus debounce FSM for one push button.
// Ports:
//   CLK, RST   - clock and synchronous active-high reset
//   BTN_IN     - raw, asynchronous, bouncing button
//   BTN_PRESS  - single-cycle pulse once a press has been stable for
//                DEBOUNCE_CYCLES synchronized samples
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic CLK,
  input  logic RST,
  input  logic BTN_IN,
  output logic BTN_PRESS
);
  import alu_input_pkg::*;

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_param
    $error("btn_debounce: DEBOUNCE_CYCLES must be >= 2");
  end

  // Guarded so an illegal parameter still yields a legal width before the error fires.
  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             s;
  db_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign s = sync_q[1];

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_q  <= 2'b00;
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], BTN_IN};
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The counter only increments while below CNT_LAST, so it saturates there
  // and can never wrap.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    BTN_PRESS = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (s) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = PRESSED;
          BTN_PRESS = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          state_d = PRESSED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/alu_input_ctrl.sv
// Sequential front end for the combinational ALU: synchronizes the switches,
// debounces the five buttons into a latched one-hot op select, and strobes
// UPDATE for one cycle whenever the op or the synchronized switches change.
// Ports:
//   CLK, RST                      - clock, synchronous active-high reset
//   SW[BITS]                      - raw switches
//   BTNC/BTNU/BTND/BTNL/BTNR      - raw buttons
//   SW_O[BITS]                    - synchronized switches
//   BTNC_O/.../BTNR_O             - latched one-hot op select
//   UPDATE                        - one-cycle change strobe
module alu_input_ctrl #(
  parameter int unsigned BITS            = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [BITS-1:0] SW,
  input  logic            BTNC,
  input  logic            BTNU,
  input  logic            BTND,
  input  logic            BTNL,
  input  logic            BTNR,
  output logic [BITS-1:0] SW_O,
  output logic            BTNC_O,
  output logic            BTNU_O,
  output logic            BTND_O,
  output logic            BTNL_O,
  output logic            BTNR_O,
  output logic            UPDATE
);
  import alu_input_pkg::*;

  logic [BITS-1:0] sw_sync1_q, sw_sync2_q;
  logic            press_c, press_u, press_d, press_l, press_r;
  logic            any_press, sw_change;
  op_t             op_q, op_d;
  logic            update_q;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_c (
    .CLK(CLK), .RST(RST), .BTN_IN(BTNC), .BTN_PRESS(press_c)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_u (
    .CLK(CLK), .RST(RST), .BTN_IN(BTNU), .BTN_PRESS(press_u)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_d (
    .CLK(CLK), .RST(RST), .BTN_IN(BTND), .BTN_PRESS(press_d)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_l (
    .CLK(CLK), .RST(RST), .BTN_IN(BTNL), .BTN_PRESS(press_l)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_r (
    .CLK(CLK), .RST(RST), .BTN_IN(BTNR), .BTN_PRESS(press_r)
  );

  // Priority U > D > L > R > C mirrors the ALU's own case(1'b1) ordering.
  always_comb begin
    op_d = op_q;
    if (press_u)      op_d = OP_LEADING_ONES;
    else if (press_d) op_d = OP_NUM_ONES;
    else if (press_l) op_d = OP_ADD;
    else if (press_r) op_d = OP_SUB;
    else if (press_c) op_d = OP_MULT;
  end

  assign any_press = press_c | press_u | press_d | press_l | press_r;
  // Stage 2 will take stage 1's value on this edge, so a difference means SW_O changes.
  assign sw_change = (sw_sync1_q != sw_sync2_q);

  always_ff @(posedge CLK) begin
    if (RST) begin
      sw_sync1_q <= '0;
      sw_sync2_q <= '0;
      op_q       <= OP_RESET;
      update_q   <= 1'b0;
    end else begin
      sw_sync1_q <= SW;
      sw_sync2_q <= sw_sync1_q;
      op_q       <= op_d;
      // Re-pressing the current op still strobes; coincident causes merge into one pulse.
      update_q   <= any_press | sw_change;
    end
  end

  assign SW_O   = sw_sync2_q;
  assign UPDATE = update_q;
  assign {BTNC_O, BTNU_O, BTND_O, BTNL_O, BTNR_O} = op_to_onehot(op_q);

endmodule

// File: tb/tb_alu_input_ctrl.sv
module tb_alu_input_ctrl;

  localparam int unsigned BITS = 16;
  localparam int unsigned DB   = 8;
  // Expected one-hot as {C, U, D, L, R}
  localparam logic [4:0] OH_U = 5'b01000;
  localparam logic [4:0] OH_D = 5'b00100;
  localparam logic [4:0] OH_L = 5'b00010;
  localparam logic [4:0] OH_R = 5'b00001;
  localparam logic [4:0] OH_C = 5'b10000;
  // Raw change driven just after edge c: sampled at c+1, op loads at c+1+DB+2.
  localparam int BTN_LAT = DB + 3;
  localparam int SW_LAT  = 2;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic [BITS-1:0] SW = '0;
  logic            BTNC = 0, BTNU = 0, BTND = 0, BTNL = 0, BTNR = 0;
  logic [BITS-1:0] SW_O;
  logic            BTNC_O, BTNU_O, BTND_O, BTNL_O, BTNR_O, UPDATE;
  logic [4:0]      oh_obs;

  assign oh_obs = {BTNC_O, BTNU_O, BTND_O, BTNL_O, BTNR_O};

  alu_input_ctrl #(.BITS(BITS), .DEBOUNCE_CYCLES(DB)) dut (
    .CLK(CLK), .RST(RST), .SW(SW),
    .BTNC(BTNC), .BTNU(BTNU), .BTND(BTND), .BTNL(BTNL), .BTNR(BTNR),
    .SW_O(SW_O),
    .BTNC_O(BTNC_O), .BTNU_O(BTNU_O), .BTND_O(BTND_O), .BTNL_O(BTNL_O), .BTNR_O(BTNR_O),
    .UPDATE(UPDATE)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         at;
    logic [4:0] oh;
    logic [15:0] sw;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  bit   armed = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic expect_update(input int at, input logic [4:0] oh, input logic [15:0] sw);
    exp_t e;
    e.at = at;
    e.oh = oh;
    e.sw = sw;
    sb.push_back(e);
  endtask

  // UPDATE must appear exactly in the cycle after each scheduled edge, never elsewhere.
  always @(negedge CLK) begin
    if (armed) begin
      if (sb.size() > 0 && cyc == sb[0].at) begin
        mon_e = sb.pop_front();
        chk("update_strobe", 32'(UPDATE), 32'd1);
        chk("update_op", 32'(oh_obs), 32'(mon_e.oh));
        chk("update_sw", 32'(SW_O), 32'(mon_e.sw));
      end else if (UPDATE !== 1'b0) begin
        chk("update_spurious", 32'(UPDATE), 32'd0);
      end
    end
  end

  int c, r;

  initial begin
    // 1. reset and idle
    step(3);
    RST = 1'b0;
    armed = 1'b1;
    chk("rst_btnu", 32'(BTNU_O), 32'd1);
    chk("rst_btnd", 32'(BTND_O), 32'd0);
    chk("rst_btnl", 32'(BTNL_O), 32'd0);
    chk("rst_btnr", 32'(BTNR_O), 32'd0);
    chk("rst_btnc", 32'(BTNC_O), 32'd0);
    chk("rst_sw_o", 32'(SW_O), 32'd0);
    chk("rst_update", 32'(UPDATE), 32'd0);
    step(20);
    chk("idle_op", 32'(oh_obs), 32'(OH_U));
    chk("idle_update", 32'(UPDATE), 32'd0);

    // 2. switch change
    SW = 16'hA5C3;
    c = cyc;
    expect_update(c + SW_LAT, OH_U, 16'hA5C3);
    step(1);
    chk("sw_not_yet", 32'(SW_O), 32'd0);
    step(1);
    chk("sw_sync", 32'(SW_O), 32'hA5C3);
    step(10);
    chk("sw_stable", 32'(SW_O), 32'hA5C3);

    // 3. clean BTNL press, long hold, release, press again
    BTNL = 1'b1;
    c = cyc;
    expect_update(c + BTN_LAT, OH_L, 16'hA5C3);
    step(BTN_LAT - 1);
    chk("btnl_early", 32'(oh_obs), 32'(OH_U));
    step(1);
    chk("btnl_op", 32'(oh_obs), 32'(OH_L));
    step(100);
    chk("btnl_hold", 32'(oh_obs), 32'(OH_L));
    BTNL = 1'b0;
    step(20);
    BTNL = 1'b1;
    c = cyc;
    expect_update(c + BTN_LAT, OH_L, 16'hA5C3);
    step(BTN_LAT + 4);
    chk("btnl_repress", 32'(oh_obs), 32'(OH_L));
    BTNL = 1'b0;
    step(20);

    // 4. bouncing BTNR: high 5, low 2, high 5, low 3, then stable
    BTNR = 1'b1; step(5);
    BTNR = 1'b0; step(2);
    BTNR = 1'b1; step(5);
    BTNR = 1'b0; step(3);
    chk("bounce_no_op", 32'(oh_obs), 32'(OH_L));
    BTNR = 1'b1;
    c = cyc;
    expect_update(c + BTN_LAT, OH_R, 16'hA5C3);
    step(BTN_LAT - 1);
    chk("btnr_early", 32'(oh_obs), 32'(OH_L));
    step(1);
    chk("btnr_op", 32'(oh_obs), 32'(OH_R));
    step(10);
    BTNR = 1'b0;
    step(20);

    // 5. simultaneous BTND + BTNC: D wins
    BTND = 1'b1;
    BTNC = 1'b1;
    c = cyc;
    expect_update(c + BTN_LAT, OH_D, 16'hA5C3);
    step(BTN_LAT + 1);
    chk("prio_btnd", 32'(BTND_O), 32'd1);
    chk("prio_btnc", 32'(BTNC_O), 32'd0);
    BTND = 1'b0;
    BTNC = 1'b0;
    step(20);

    // 6. reset mid-debounce with BTNC held through release
    BTNC = 1'b1;
    step(8);
    RST = 1'b1;
    step(1);
    RST = 1'b0;
    r = cyc;
    chk("mid_rst_op", 32'(oh_obs), 32'(OH_U));
    chk("mid_rst_sw", 32'(SW_O), 32'd0);
    chk("mid_rst_update", 32'(UPDATE), 32'd0);
    expect_update(r + SW_LAT, OH_U, 16'hA5C3);
    expect_update(r + BTN_LAT, OH_C, 16'hA5C3);
    step(BTN_LAT - 1);
    chk("post_rst_early", 32'(BTNC_O), 32'd0);
    step(1);
    chk("post_rst_btnc", 32'(BTNC_O), 32'd1);
    step(20);
    BTNC = 1'b0;
    step(20);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
